// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback-stage register-file write path.
//   DATA_W / SEL_W / NUM_REGS : register file geometry
//   wb_arb_state_t            : write-port arbiter states
//   wb_wr_t                   : one register-file write (destination + data)
//   sel_onehot()              : destination select -> one-hot register mask
package wb_pkg;

  localparam int DATA_W   = 16;
  localparam int SEL_W    = 3;
  localparam int NUM_REGS = 8;

  typedef enum logic {ARB_NORMAL, ARB_DRAIN} wb_arb_state_t;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } wb_wr_t;

  function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    return NUM_REGS'(1) << s;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding multi-cycle unit results until they win the
// register-file write port. Head entry is visible combinationally on dout.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, din  : enqueue din (caller guarantees !full)
//   pop        : dequeue head (caller guarantees !empty)
//   dout       : current head entry
//   count      : occupancy, full, empty : status from registered count
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  wb_wr_t                     din,
  input  logic                       pop,
  output wb_wr_t                     dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_wr_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/wb_write_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// pipeline writeback (priority) and buffered multi-cycle unit results.
// Tracks destinations with outstanding multi-cycle writes for the hazard unit
// and forces a one-cycle pipeline stall to drain the FIFO when the pipeline
// has won MAX_STARVE consecutive grants while results were waiting.
//   clk, rst_n                   : clock, synchronous active-low reset
//   pipe_wen/pipe_sel/pipe_data  : pipeline writeback request
//   pipe_stall                   : freeze pipeline (drain cycle)
//   mc_issue/mc_issue_sel        : multi-cycle op issued (marks dest pending)
//   mc_valid/mc_sel/mc_data      : multi-cycle result, accepted when mc_ready
//   mc_ready                     : FIFO has room (registered count based)
//   rf_wen/rf_sel/rf_data        : registered register-file write port
//   pend_mask                    : registers with outstanding multi-cycle writes
//   fifo_cnt                     : result FIFO occupancy
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int MAX_STARVE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pipe_wen,
  input  logic [SEL_W-1:0]       pipe_sel,
  input  logic [DATA_W-1:0]      pipe_data,
  output logic                   pipe_stall,
  input  logic                   mc_issue,
  input  logic [SEL_W-1:0]       mc_issue_sel,
  input  logic                   mc_valid,
  output logic                   mc_ready,
  input  logic [SEL_W-1:0]       mc_sel,
  input  logic [DATA_W-1:0]      mc_data,
  output logic                   rf_wen,
  output logic [SEL_W-1:0]       rf_sel,
  output logic [DATA_W-1:0]      rf_data,
  output logic [NUM_REGS-1:0]    pend_mask,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int ST_W = $clog2(MAX_STARVE + 1);

  wb_arb_state_t         state, state_nxt;
  logic [ST_W-1:0]       starve_cnt, starve_nxt;

  logic                  fifo_full, fifo_empty;
  wb_wr_t                fifo_head, mc_wr, wr;
  logic                  push, grant_pipe, grant_fifo;
  logic [NUM_REGS-1:0]   set_vec, clr_vec;

  assign mc_wr = '{sel: mc_sel, data: mc_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (mc_wr),
    .pop   (grant_fifo),
    .dout  (fifo_head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Handshake and grant. A result pushed this cycle cannot be granted this
  // cycle (no bypass), and mc_ready gets no credit for a same-cycle pop.
  always_comb begin
    pipe_stall = rst_n && (state == ARB_DRAIN);
    mc_ready   = rst_n && !fifo_full;
    push       = mc_valid && mc_ready;
    grant_pipe = !pipe_stall && pipe_wen;
    grant_fifo = !grant_pipe && !fifo_empty;
    wr         = grant_pipe ? '{sel: pipe_sel, data: pipe_data} : fifo_head;
  end

  // Starvation FSM: count pipeline wins over a waiting FIFO; on reaching
  // MAX_STARVE spend one stalled cycle granting the FIFO head.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      ARB_NORMAL: begin
        if (grant_pipe && !fifo_empty) begin
          if (starve_cnt == ST_W'(MAX_STARVE - 1)) begin
            state_nxt  = ARB_DRAIN;
            starve_nxt = '0;
          end else begin
            starve_nxt = starve_cnt + 1'b1;
          end
        end else begin
          starve_nxt = '0;
        end
      end
      ARB_DRAIN: begin
        state_nxt  = ARB_NORMAL;
        starve_nxt = '0;
      end
      default: begin
        state_nxt  = ARB_NORMAL;
        starve_nxt = '0;
      end
    endcase
  end

  // Scoreboard: clear lands on the same edge the FIFO write reaches rf_wen;
  // a new issue to that register on the same edge wins.
  always_comb begin
    set_vec = mc_issue   ? sel_onehot(mc_issue_sel)  : '0;
    clr_vec = grant_fifo ? sel_onehot(fifo_head.sel) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB_NORMAL;
      starve_cnt <= '0;
      rf_wen     <= 1'b0;
      rf_sel     <= '0;
      rf_data    <= '0;
      pend_mask  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      rf_wen     <= grant_pipe || grant_fifo;
      if (grant_pipe || grant_fifo) begin
        rf_sel  <= wr.sel;
        rf_data <= wr.data;
      end
      pend_mask  <= (pend_mask & ~clr_vec) | set_vec;
    end
  end

  // A back-pressured result (mc_valid && !mc_ready) is legal: the producer
  // holds it. Re-issuing to a still-pending destination is not.
  always_ff @(posedge clk) begin
    if (rst_n && mc_issue)
      assert (((pend_mask & ~clr_vec) & sel_onehot(mc_issue_sel)) == '0)
        else $error("wb_write_arbiter: mc_issue to pending reg %0d", mc_issue_sel);
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;
  import wb_pkg::*;

  localparam int DEPTH      = 2;
  localparam int MAX_STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_wen = 1'b0;
  logic [2:0]  pipe_sel = '0;
  logic [15:0] pipe_data = '0;
  logic        pipe_stall;
  logic        mc_issue = 1'b0;
  logic [2:0]  mc_issue_sel = '0;
  logic        mc_valid = 1'b0;
  logic        mc_ready;
  logic [2:0]  mc_sel = '0;
  logic [15:0] mc_data = '0;
  logic        rf_wen;
  logic [2:0]  rf_sel;
  logic [15:0] rf_data;
  logic [7:0]  pend_mask;
  logic [1:0]  fifo_cnt;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(DEPTH), .MAX_STARVE(MAX_STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wen(pipe_wen), .pipe_sel(pipe_sel), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .mc_issue(mc_issue), .mc_issue_sel(mc_issue_sel),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_sel(mc_sel), .mc_data(mc_data),
    .rf_wen(rf_wen), .rf_sel(rf_sel), .rf_data(rf_data),
    .pend_mask(pend_mask), .fifo_cnt(fifo_cnt)
  );

  int nasserts = 0;
  int nfails   = 0;

  // Reference model: a queue of buffered results, a pending-register set,
  // the expected write port, and a count of consecutive pipeline wins.
  wb_wr_t      m_q[$];
  int          m_starve = 0;
  bit          m_drain  = 0;
  logic [7:0]  m_pend   = '0;
  logic        m_wen    = 1'b0;
  logic [2:0]  m_sel    = '0;
  logic [15:0] m_data   = '0;
  bit          m_acc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nasserts++;
    assert (obs === exp) else begin
      nfails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit     waiting;
    bit     room;
    bit     pipe_wins;
    wb_wr_t e;
    m_acc = 0;
    if (!rst_n) begin
      m_q.delete();
      m_starve = 0; m_drain = 0; m_pend = '0;
      m_wen = 1'b0; m_sel = '0; m_data = '0;
      return;
    end
    waiting   = (m_q.size() > 0);
    room      = (m_q.size() < DEPTH);
    pipe_wins = !m_drain && pipe_wen;
    m_wen = 1'b0;
    if (pipe_wins) begin
      m_wen = 1'b1; m_sel = pipe_sel; m_data = pipe_data;
    end else if (waiting) begin
      e = m_q.pop_front();
      m_wen = 1'b1; m_sel = e.sel; m_data = e.data;
      m_pend[e.sel] = 1'b0;
    end
    if (mc_issue) m_pend[mc_issue_sel] = 1'b1;
    if (mc_valid && room) begin
      e.sel = mc_sel; e.data = mc_data;
      m_q.push_back(e);
      m_acc = 1;
    end
    if (m_drain) begin
      m_drain = 0; m_starve = 0;
    end else if (pipe_wins && waiting) begin
      m_starve++;
      if (m_starve == MAX_STARVE) begin
        m_drain = 1; m_starve = 0;
      end
    end else begin
      m_starve = 0;
    end
  endtask

  // One clock: check combinational outputs, advance model, check registers.
  task automatic cyc();
    #1;
    chk("pipe_stall", pipe_stall, rst_n && m_drain);
    chk("mc_ready", mc_ready, rst_n && (m_q.size() < DEPTH));
    model_edge();
    @(posedge clk);
    #1;
    chk("rf_wen", rf_wen, m_wen);
    chk("rf_sel", rf_sel, m_sel);
    chk("rf_data", rf_data, m_data);
    chk("pend_mask", pend_mask, m_pend);
    chk("fifo_cnt", fifo_cnt, m_q.size());
  endtask

  initial begin
    int r;
    bit holding;
    holding = 0;

    // 1: reset then idle
    rst_n = 1'b0;
    cyc();
    chk("t1_ready_in_rst", mc_ready, 0);
    cyc();
    chk("t1_wen_rst", rf_wen, 0);
    chk("t1_pend_rst", pend_mask, 8'h00);
    chk("t1_cnt_rst", fifo_cnt, 0);
    rst_n = 1'b1;
    #1 chk("t1_ready_after", mc_ready, 1);
    cyc();

    // 2: pipeline-only write, then hold
    pipe_wen = 1'b1; pipe_sel = 3'd3; pipe_data = 16'hBEEF;
    cyc();
    chk("t2_wen", rf_wen, 1);
    chk("t2_sel", rf_sel, 3);
    chk("t2_data", rf_data, 16'hBEEF);
    pipe_wen = 1'b0;
    cyc();
    chk("t2_idle_wen", rf_wen, 0);
    chk("t2_hold_data", rf_data, 16'hBEEF);

    // 3: multi-cycle only, scoreboard set/clear
    mc_issue = 1'b1; mc_issue_sel = 3'd5;
    cyc();
    mc_issue = 1'b0;
    chk("t3_pend_set", pend_mask, 8'h20);
    cyc(); cyc();
    mc_valid = 1'b1; mc_sel = 3'd5; mc_data = 16'h1234;
    cyc();
    mc_valid = 1'b0;
    chk("t3_pend_held", pend_mask, 8'h20);
    chk("t3_no_bypass", rf_wen, 0);
    chk("t3_cnt", fifo_cnt, 1);
    cyc();
    chk("t3_wen", rf_wen, 1);
    chk("t3_sel", rf_sel, 5);
    chk("t3_data", rf_data, 16'h1234);
    chk("t3_pend_clr", pend_mask, 8'h00);

    // 4: collision, pipe first then multi-cycle result
    mc_issue = 1'b1; mc_issue_sel = 3'd2;
    cyc();
    mc_issue = 1'b0;
    pipe_wen = 1'b1; pipe_sel = 3'd1; pipe_data = 16'h1111;
    mc_valid = 1'b1; mc_sel = 3'd2; mc_data = 16'h2222;
    cyc();
    pipe_wen = 1'b0; mc_valid = 1'b0;
    chk("t4_pipe_sel", rf_sel, 1);
    chk("t4_pipe_data", rf_data, 16'h1111);
    cyc();
    chk("t4_mc_wen", rf_wen, 1);
    chk("t4_mc_sel", rf_sel, 2);
    chk("t4_mc_data", rf_data, 16'h2222);
    chk("t4_pend", pend_mask, 8'h00);

    // 5: starvation drain
    mc_valid = 1'b1; mc_sel = 3'd6; mc_data = 16'h6666;
    cyc();
    mc_valid = 1'b0;
    pipe_wen = 1'b1; pipe_sel = 3'd0;
    for (int i = 0; i < 4; i++) begin
      pipe_data = 16'hA000 + 16'(i);
      #1 chk("t5_no_stall", pipe_stall, 0);
      cyc();
      chk("t5_pipe_wen", rf_wen, 1);
      chk("t5_pipe_data", rf_data, 16'hA000 + 16'(i));
    end
    pipe_data = 16'hA004;
    #1 chk("t5_stall", pipe_stall, 1);
    cyc();
    chk("t5_drain_sel", rf_sel, 6);
    chk("t5_drain_data", rf_data, 16'h6666);
    chk("t5_drain_cnt", fifo_cnt, 0);
    #1 chk("t5_stall_done", pipe_stall, 0);
    cyc();
    chk("t5_resume", rf_data, 16'hA004);
    pipe_wen = 1'b0;
    cyc();

    // 6: fill FIFO behind the pipeline, then reset mid-stream
    mc_issue = 1'b1; mc_issue_sel = 3'd3;
    cyc();
    mc_issue_sel = 3'd4;
    cyc();
    mc_issue = 1'b0;
    pipe_wen = 1'b1; pipe_sel = 3'd7; pipe_data = 16'h7777;
    mc_valid = 1'b1; mc_sel = 3'd3; mc_data = 16'h3333;
    cyc();
    mc_sel = 3'd4; mc_data = 16'h4444;
    cyc();
    mc_valid = 1'b0;
    chk("t6_full_cnt", fifo_cnt, 2);
    chk("t6_pend", pend_mask, 8'h18);
    #1 chk("t6_not_ready", mc_ready, 0);
    rst_n = 1'b0;
    cyc();
    chk("t6_rst_cnt", fifo_cnt, 0);
    chk("t6_rst_pend", pend_mask, 8'h00);
    chk("t6_rst_wen", rf_wen, 0);
    rst_n = 1'b1; pipe_wen = 1'b0;
    cyc();
    chk("t6_no_write", rf_wen, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      pipe_wen  = ($urandom_range(0, 3) != 0);
      pipe_sel  = 3'($urandom);
      pipe_data = 16'($urandom);
      if (!holding && $urandom_range(0, 2) == 0) begin
        holding = 1;
        mc_sel  = 3'($urandom);
        mc_data = 16'($urandom);
      end
      mc_valid = holding;
      r = $urandom_range(0, 7);
      mc_issue_sel = 3'(r);
      mc_issue = rst_n && ($urandom_range(0, 3) == 0) && !m_pend[r];
      cyc();
      if (m_acc || !rst_n) holding = 0;
    end
    rst_n = 1'b1; pipe_wen = 1'b0; mc_valid = 1'b0; mc_issue = 1'b0;
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfails);
    $finish;
  end

endmodule
